// File: rtl/wr_ptr_ctrl.sv
// wr_ptr_ctrl: write-side pointer and flag controller of an asynchronous FIFO.
// Lives entirely in the wr_clk domain. Keeps the binary/Gray write pointers,
// synchronises the read-domain Gray pointer and derives registered full,
// almost_full, fill level and (optionally) a sticky overflow flag.
// Optional feature macro: WR_PTR_CTRL_OVF_EN (sticky overflow logic).
module wr_ptr_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic                  ovf_clr,
    output logic                  wr_inc,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rq_s;
    logic [PW-1:0] rq_bin_s;
    logic [PW-1:0] full_cmp_s;
    logic          wr_inc_s;

    // Reset gates the request so nothing reaches the RAM while wr_rstn is low.
    assign wr_inc_s = wr_en & ~full_q & wr_rstn;

    // Next pointer, full compare, level and almost-full, all from the next pointer
    // so that the flags line up with the edge that accepts the write.
    always_comb begin
        bin_d      = bin_q + {{ADDR_WIDTH{1'b0}}, wr_inc_s};
        gray_d     = bin_d ^ (bin_d >> 1);
        rq_s       = sync_q[SYNC_STAGES-1];
        rq_bin_s   = gray2bin(rq_s);
        full_cmp_s = {~rq_s[PW-1:PW-2], rq_s[PW-3:0]};
        full_d     = (gray_d == full_cmp_s);
        level_d    = bin_d - rq_bin_s;
        afull_d    = (afull_thresh != {PW{1'b0}}) && (level_d >= afull_thresh);
    end

    // Plain flop chain bringing the read Gray pointer into wr_clk; no logic between stages.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {PW{1'b0}};
            end
        end else begin
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            bin_q   <= {PW{1'b0}};
            gray_q  <= {PW{1'b0}};
            level_q <= {PW{1'b0}};
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

`ifdef WR_PTR_CTRL_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a write attempt while full sets it and wins over a clear.
    always_comb begin
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr_s;
    assign unused_ovf_clr_s = ovf_clr;
    assign overflow         = 1'b0;
`endif

    assign wr_inc      = wr_inc_s;
    assign wr_addr     = bin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// tb_wr_ptr_ctrl: directed self-checking bench for wr_ptr_ctrl (ADDR_WIDTH=3, SYNC_STAGES=2).
module tb_wr_ptr_ctrl;

`ifdef WR_PTR_CTRL_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic       wr_clk;
    logic       wr_rstn;
    logic       wr_en;
    logic [3:0] rd_ptr_gray;
    logic [3:0] afull_thresh;
    logic       ovf_clr;
    logic       wr_inc;
    logic [2:0] wr_addr;
    logic [3:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int total;
    int bad;
    logic [3:0] m;

    wr_ptr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2)) dut (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
        .afull_thresh(afull_thresh), .ovf_clr(ovf_clr), .wr_inc(wr_inc), .wr_addr(wr_addr),
        .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
        .wr_level(wr_level), .overflow(overflow)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = i[0];
            #1;
            total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL rst_wr_inc: got %0b exp 0", wr_inc); end
            tick();
            total++;
            if ({wr_addr, wr_ptr_gray, full, almost_full, wr_level, overflow} !== 14'd0) begin
                bad++; $display("FAIL rst_outputs: gray=%0h lvl=%0d full=%0b af=%0b ovf=%0b exp all 0",
                                wr_ptr_gray, wr_level, full, almost_full, overflow);
            end
        end
        wr_en   = 1'b0;
        wr_rstn = 1'b1;
        tick();
        tick();
        total++;
        if ({wr_addr, wr_ptr_gray, full, almost_full, wr_level, overflow} !== 14'd0) begin
            bad++; $display("FAIL post_rst_idle: gray=%0h lvl=%0d full=%0b exp all 0", wr_ptr_gray, wr_level, full);
        end
    endtask

    task automatic test_fill_afull();
        afull_thresh = 4'd6;
        rd_ptr_gray  = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            #1;
            total++; if (wr_inc !== 1'b1) begin bad++; $display("FAIL fill_wr_inc[%0d]: got %0b exp 1", i, wr_inc); end
            tick();
            total++; if (wr_level !== 4'(i)) begin bad++; $display("FAIL fill_level[%0d]: got %0d exp %0d", i, wr_level, i); end
            total++; if (almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_afull[%0d]: got %0b exp %0b", i, almost_full, (i >= 6)); end
            total++; if (full !== (i == 8)) begin bad++; $display("FAIL fill_full[%0d]: got %0b exp %0b", i, full, (i == 8)); end
        end
        total++; if (wr_ptr_gray !== 4'b1100) begin bad++; $display("FAIL full_gray: got %b exp 1100", wr_ptr_gray); end
        total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL full_addr: got %0d exp 0", wr_addr); end
        // 9th write is rejected
        wr_en = 1'b1;
        #1;
        total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL ovf_wr_inc: got %0b exp 0", wr_inc); end
        tick();
        total++; if (wr_ptr_gray !== 4'b1100) begin bad++; $display("FAIL ovf_gray: got %b exp 1100", wr_ptr_gray); end
        total++; if (wr_level !== 4'd8) begin bad++; $display("FAIL ovf_level: got %0d exp 8", wr_level); end
        total++; if (overflow !== OVF) begin bad++; $display("FAIL ovf_set: got %0b exp %0b", overflow, OVF); end
        // clear together with a write attempt: set wins
        ovf_clr = 1'b1;
        tick();
        total++; if (overflow !== OVF) begin bad++; $display("FAIL ovf_set_wins: got %0b exp %0b", overflow, OVF); end
        wr_en = 1'b0;
        tick();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0b exp 0", overflow); end
        ovf_clr = 1'b0;
    endtask

    task automatic test_afull_disable();
        afull_thresh = 4'd0;
        tick();
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL afull_zero: got %0b exp 0", almost_full); end
        afull_thresh = 4'd9;
        tick();
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL afull_above_depth: got %0b exp 0", almost_full); end
        afull_thresh = 4'd0;
    endtask

    task automatic test_read_release();
        rd_ptr_gray = 4'b0011;
        for (int e = 1; e <= 2; e++) begin
            tick();
            total++; if (full !== 1'b1) begin bad++; $display("FAIL rel_full_hold[%0d]: got %0b exp 1", e, full); end
            total++; if (wr_level !== 4'd8) begin bad++; $display("FAIL rel_level_hold[%0d]: got %0d exp 8", e, wr_level); end
        end
        tick();
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rel_full: got %0b exp 0", full); end
        total++; if (wr_level !== 4'd6) begin bad++; $display("FAIL rel_level: got %0d exp 6", wr_level); end
    endtask

    task automatic test_wrap();
        m = 4'd8;
        rd_ptr_gray = g(4'd7);
        tick(); tick(); tick();
        total++; if (wr_level !== 4'd1) begin bad++; $display("FAIL wrap_pre_level: got %0d exp 1", wr_level); end
        for (int j = 0; j < 20; j++) begin
            rd_ptr_gray = g(m - 4'd1);
            wr_en = 1'b1;
            tick();
            m = m + 4'd1;
            total++; if (wr_ptr_gray !== g(m)) begin bad++; $display("FAIL wrap_gray[%0d]: got %b exp %b", j, wr_ptr_gray, g(m)); end
            total++; if (wr_addr !== m[2:0]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d exp %0d", j, wr_addr, m[2:0]); end
            total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full[%0d]: got %0b exp 0", j, full); end
        end
        wr_en = 1'b0;
        rd_ptr_gray = g(m - 4'd1);
        tick(); tick(); tick();
        total++; if (wr_level !== 4'd1) begin bad++; $display("FAIL wrap_level: got %0d exp 1", wr_level); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full_end: got %0b exp 0", full); end
    endtask

    task automatic test_mid_reset();
        // refill from level 1 to full (read pointer held at m-1)
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1;
            tick();
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL refill_full: got %0b exp 1", full); end
        total++; if (wr_level !== 4'd8) begin bad++; $display("FAIL refill_level: got %0d exp 8", wr_level); end
        tick();
        total++; if (overflow !== OVF) begin bad++; $display("FAIL refill_ovf: got %0b exp %0b", overflow, OVF); end
        #2;
        wr_rstn     = 1'b0;
        rd_ptr_gray = 4'd0;
        #1;
        total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL midrst_wr_inc: got %0b exp 0", wr_inc); end
        total++;
        if ({wr_addr, wr_ptr_gray, full, almost_full, wr_level, overflow} !== 14'd0) begin
            bad++; $display("FAIL midrst_outputs: gray=%0h lvl=%0d full=%0b ovf=%0b exp all 0",
                            wr_ptr_gray, wr_level, full, overflow);
        end
        wr_rstn = 1'b1;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        total++; if (wr_ptr_gray !== 4'b0001) begin bad++; $display("FAIL midrst_first_gray: got %b exp 0001", wr_ptr_gray); end
        total++; if (wr_level !== 4'd1) begin bad++; $display("FAIL midrst_first_level: got %0d exp 1", wr_level); end
        total++; if (wr_addr !== 3'd1) begin bad++; $display("FAIL midrst_first_addr: got %0d exp 1", wr_addr); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        wr_rstn      = 1'b0;
        wr_en        = 1'b0;
        rd_ptr_gray  = 4'd0;
        afull_thresh = 4'd0;
        ovf_clr      = 1'b0;
        m            = 4'd0;
        test_reset();
        test_fill_afull();
        test_afull_disable();
        test_read_release();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
Write-side pointer and flag controller for the asynchronous FIFO, in the wr_clk domain. It holds the binary and Gray write pointers and synchronises the read-domain Gray pointer internally (SYNC_STAGES flops). From these it produces registered full, almost_full, fill level and a sticky overflow flag. It feeds the dual-port RAM write port and the read-side controller.

Parameters:
ADDR_WIDTH, 8, RAM address width; FIFO depth = 2**ADDR_WIDTH; legal minimum 2.
SYNC_STAGES, 2, flops in the rd_ptr_gray synchroniser; legal minimum 2.

Ports:
wr_clk  in  1  write-domain clock.
wr_rstn  in  1  asynchronous, active-low reset.
wr_en  in  1  write request from the producer.
rd_ptr_gray  in  ADDR_WIDTH+1  Gray read pointer from the read domain; asynchronous to wr_clk.
afull_thresh  in  ADDR_WIDTH+1  almost-full level threshold; quasi-static; 0 disables the flag.
ovf_clr  in  1  clears the sticky overflow flag.
wr_inc  out  1  write accepted this cycle; drives the RAM write enable.
wr_addr  out  ADDR_WIDTH  RAM write address = low bits of the binary pointer.
wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
full  out  1  FIFO full.
almost_full  out  1  level >= afull_thresh.
wr_level  out  ADDR_WIDTH+1  entries held, as seen through the synchronised read pointer.
overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (asynchronous, wr_rstn low): binary pointer, wr_ptr_gray, every synchroniser flop, full, almost_full, wr_level and overflow go to 0, with no clock needed. wr_addr = 0. wr_inc = 0, because wr_en is gated by the reset state.
- Accept: wr_inc = wr_en & ~full. This is combinational and is the only path that advances the pointer.
- Next pointers:
  - bin_next = bin + wr_inc, modulo 2**(ADDR_WIDTH+1).
  - gray_next = bin_next ^ (bin_next >> 1).
  - Both are registered on posedge wr_clk.
- Synchroniser:
  - rq = rd_ptr_gray after SYNC_STAGES flops. No logic is placed between the flops.
  - rq_bin = Gray-to-binary of rq (XOR prefix from the MSB).
- full:
  - Register of (gray_next == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]}).
  - It asserts on the same edge that accepts the write filling the last entry, so zero-latency back-pressure is seen by the next request.
  - It deasserts SYNC_STAGES+1 edges after rd_ptr_gray changes (pessimistic, never optimistic).
- wr_level: register of (bin_next - rq_bin), modulo 2**(ADDR_WIDTH+1). Range 0..2**ADDR_WIDTH. It equals 2**ADDR_WIDTH exactly when full.
- almost_full: register of (afull_thresh != 0) & (level_next >= afull_thresh). A threshold above the depth never asserts.
- overflow:
  - Set when wr_en & full. Cleared when ovf_clr.
  - Set and clear in the same cycle: set wins.
  - The rejected write does not modify the pointer, the RAM or wr_level.
- Wrap-around: the binary pointer wraps from 2**(ADDR_WIDTH+1)-1 to 0, and the Gray pointer wraps by a single-bit change. A wrap must never produce a false full or a false level.
- Simultaneous write and read release: the pointer advances and the level reflects both. full may stay asserted for SYNC_STAGES+1 edges after the read, which is acceptable.
- Reset mid-operation: all state clears immediately. Any write in flight is dropped and wr_inc = 0 during reset.

Optional Feature:
Macro WR_PTR_CTRL_OVF_EN.
- Defined: the overflow sticky logic is built as described above.
- Undefined: overflow is tied to 0, ovf_clr is ignored, and no flop is inferred. Ports are identical in both builds.

Test Plan:
Bench uses ADDR_WIDTH=3 and SYNC_STAGES=2.
- Reset check: hold wr_rstn=0 and toggle wr_en → all outputs 0 and wr_inc=0. Release reset → outputs stay 0 until the first write.
- Fill to full:
  - Stimulus: rd_ptr_gray=0, 8 consecutive wr_en.
  - After the 8th accepting edge: full=1, wr_level=8, wr_ptr_gray=4'b1100, wr_addr=0.
  - 9th wr_en → wr_inc=0, pointer unchanged, overflow=1.
  - ovf_clr together with wr_en while full → overflow stays 1. ovf_clr alone → overflow=0.
- almost_full: afull_thresh=6 with single writes → almost_full=1 on the edge accepting the 6th write, 0 before it. afull_thresh=0 → never asserts.
- Read release: from full, drive rd_ptr_gray=4'b0011 (bin 2) → full=0 and wr_level=6 exactly 3 edges later. Checks in between show full=1 and level=8.
- Wrap: 20 writes with rd_ptr_gray tracking gray(bin-1) each cycle.
  - Binary pointer passes 15→0, with wr_ptr_gray 4'b1000→4'b0000.
  - full is never asserted and wr_level settles to 1.
- Mid-operation reset: pulse wr_rstn low for 1 ns while full=1 and overflow=1, between clock edges → all outputs 0 immediately. The first write after release → wr_ptr_gray=4'b0001.
